// File: rtl/uart_rx_unit.sv
// UART receiver: 16x oversampled, 8 data bits LSB first, optional parity, 1 stop bit.
// done_flag pulses 3 cycles after the line-side stop-bit mid-sample; there is no backpressure.
module uart_rx_unit #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       data_rx,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic [7:0] data_out,
    output logic       parity_error,
    output logic       stop_error,
    output logic       active_flag,
    output logic       done_flag
);

    localparam logic [15:0] DIV_2400  = 16'((CLK_FREQ + 2400 * 8) / (2400 * 16));
    localparam logic [15:0] DIV_4800  = 16'((CLK_FREQ + 4800 * 8) / (4800 * 16));
    localparam logic [15:0] DIV_9600  = 16'((CLK_FREQ + 9600 * 8) / (9600 * 16));
    localparam logic [15:0] DIV_19200 = 16'((CLK_FREQ + 19200 * 8) / (19200 * 16));
    localparam logic [3:0]  OS_LAST   = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]  OS_MID    = 4'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t      state, next_state;
    logic        rx_meta, rx_s;
    logic [1:0]  lat_baud, lat_par;
    logic [15:0] div_cnt, div_sel;
    logic [3:0]  os_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        par_bit;
    logic        tick, mid;
    logic        go_start, false_start, shift_en, par_en, finish;
    logic        par_xor, par_err_calc;

    always_comb begin
        case (lat_baud)
            2'b00:   div_sel = DIV_2400;
            2'b01:   div_sel = DIV_4800;
            2'b10:   div_sel = DIV_9600;
            default: div_sel = DIV_19200;
        endcase
    end

    assign tick = (div_cnt == div_sel - 16'd1);
    assign mid  = tick && (os_cnt == OS_MID);

    assign par_xor = ^{shift_reg, par_bit};
    assign par_err_calc = (lat_par == 2'b01) ? ~par_xor :
                          (lat_par == 2'b10) ?  par_xor : 1'b0;

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state  = state;
        go_start    = 1'b0;
        false_start = 1'b0;
        shift_en    = 1'b0;
        par_en      = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: if (!rx_s) begin
                next_state = START;
                go_start   = 1'b1;
            end
            START: if (mid) begin
                next_state  = rx_s ? IDLE : DATA;
                false_start = rx_s;
            end
            DATA: if (mid) begin
                shift_en = 1'b1;
                if (bit_cnt == 3'd7)
                    next_state = (lat_par == 2'b01 || lat_par == 2'b10) ? PARITY : STOP;
            end
            PARITY: if (mid) begin
                par_en     = 1'b1;
                next_state = STOP;
            end
            STOP: if (mid) begin
                finish = 1'b1;
                // A line still low at mid-stop is a break; wait it out before hunting for a start edge.
                next_state = rx_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: if (rx_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            lat_baud     <= 2'b00;
            lat_par      <= 2'b00;
            div_cnt      <= '0;
            os_cnt       <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            par_bit      <= 1'b0;
            data_out     <= '0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            active_flag  <= 1'b0;
            done_flag    <= 1'b0;
        end else begin
            rx_meta   <= data_rx;
            rx_s      <= rx_meta;
            done_flag <= 1'b0;
            if (go_start) begin
                lat_baud    <= baud_rate;
                lat_par     <= parity_type;
                div_cnt     <= '0;
                os_cnt      <= '0;
                bit_cnt     <= '0;
                active_flag <= 1'b1;
            end else if (state != IDLE) begin
                if (tick) begin
                    div_cnt <= '0;
                    os_cnt  <= (os_cnt == OS_LAST) ? 4'd0 : os_cnt + 4'd1;
                end else begin
                    div_cnt <= div_cnt + 16'd1;
                end
            end
            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end
            if (par_en)
                par_bit <= rx_s;
            if (false_start)
                active_flag <= 1'b0;
            if (finish) begin
                data_out     <= shift_reg;
                parity_error <= par_err_calc;
                stop_error   <= ~rx_s;
                done_flag    <= 1'b1;
                active_flag  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Scoreboard bench for uart_rx_unit: a serial line driver pushes expected frames, a monitor pops on done_flag.
module tb_uart_rx_unit;

    localparam int CLK = 1_000_000;

    logic       clock;
    logic       reset_n;
    logic       data_rx;
    logic [1:0] parity_type;
    logic [1:0] baud_rate;
    logic [7:0] data_out;
    logic       parity_error;
    logic       stop_error;
    logic       active_flag;
    logic       done_flag;

    int vectors = 0;
    int miscompares = 0;
    logic [9:0] exp_q[$];
    logic [9:0] last_exp = '0;
    bit prev_done = 0;

    uart_rx_unit #(.CLK_FREQ(CLK), .OVERSAMPLE(16)) dut (
        .clock(clock), .reset_n(reset_n), .data_rx(data_rx),
        .parity_type(parity_type), .baud_rate(baud_rate),
        .data_out(data_out), .parity_error(parity_error), .stop_error(stop_error),
        .active_flag(active_flag), .done_flag(done_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout simulation did not complete within bound");
        $fatal(1, "timeout");
    end

    function automatic int div_of(input logic [1:0] br);
        int baud;
        baud = 2400 << br;
        return (CLK + baud * 8) / (baud * 16);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        logic [9:0] e;
        if (done_flag === 1'b1) begin
            check("done_single_cycle", 8'(prev_done), 8'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done got done_flag=1 expected no frame at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("data_out", data_out, e[9:2]);
                check("parity_error", 8'(parity_error), 8'(e[1]));
                check("stop_error", 8'(stop_error), 8'(e[0]));
                check("active_at_done", 8'(active_flag), 8'd0);
            end
        end
        prev_done = (done_flag === 1'b1);
    end

    // Drives one frame; abort_at >= 0 pulls reset low at that data bit and keeps it low to frame end.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] br,
                              input bit flip_par, input bit stop_val, input int hold_low,
                              input int abort_at);
        int bp;
        bit has_par;
        logic pbit;
        logic [9:0] e;
        bp = 16 * div_of(br);
        has_par = (pt == 2'b01) || (pt == 2'b10);
        pbit = (pt == 2'b01) ? ~(^d) : (^d);
        if (flip_par) pbit = ~pbit;
        if (abort_at < 0) begin
            e = {d, has_par & flip_par, ~stop_val};
            exp_q.push_back(e);
            last_exp = e;
        end
        @(negedge clock);
        parity_type = pt;
        baud_rate   = br;
        data_rx     = 1'b0;
        repeat (bp) @(negedge clock);
        parity_type = 2'($urandom);
        baud_rate   = 2'($urandom);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_at) reset_n = 1'b0;
            data_rx = d[i];
            repeat (bp / 2) @(negedge clock);
            if (i == 3 && (abort_at < 0 || abort_at > 3))
                check("active_mid_frame", 8'(active_flag), 8'd1);
            repeat (bp - bp / 2) @(negedge clock);
        end
        if (has_par) begin
            data_rx = pbit;
            repeat (bp) @(negedge clock);
        end
        data_rx = stop_val;
        repeat (bp) @(negedge clock);
        if (!stop_val) begin
            repeat (hold_low * bp) @(negedge clock);
            data_rx = 1'b1;
            repeat (2 * bp) @(negedge clock);
        end
        data_rx = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clock);
            n++;
        end
        check("queue_drained", 8'(exp_q.size()), 8'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        data_rx     = 1'b1;
        parity_type = 2'b00;
        baud_rate   = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            data_rx = ~data_rx;
        end
        data_rx = 1'b1;
        check("rst_data_out", data_out, 8'h00);
        check("rst_parity_error", 8'(parity_error), 8'd0);
        check("rst_stop_error", 8'(stop_error), 8'd0);
        check("rst_active_flag", 8'(active_flag), 8'd0);
        check("rst_done_flag", 8'(done_flag), 8'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        send_frame(8'h54, 2'b01, 2'b10, 0, 1, 0, -1);
        send_frame(8'h54, 2'b10, 2'b10, 1, 1, 0, -1);
        drain();

        // False start: 3 ticks low at 9600, then back high before mid-start.
        @(negedge clock);
        baud_rate   = 2'b10;
        parity_type = 2'b00;
        data_rx     = 1'b0;
        repeat (2 * div_of(2'b10)) @(negedge clock);
        check("false_start_active_rise", 8'(active_flag), 8'd1);
        repeat (div_of(2'b10)) @(negedge clock);
        data_rx = 1'b1;
        repeat (16 * div_of(2'b10)) @(negedge clock);
        check("false_start_active_fall", 8'(active_flag), 8'd0);
        check("false_start_data_held", data_out, last_exp[9:2]);
        check("false_start_pe_held", 8'(parity_error), 8'(last_exp[1]));
        check("false_start_se_held", 8'(stop_error), 8'(last_exp[0]));

        send_frame(8'hA5, 2'b00, 2'b10, 0, 0, 3, -1);
        send_frame(8'h3C, 2'b00, 2'b10, 0, 1, 0, -1);

        send_frame(8'h00, 2'b00, 2'b11, 0, 1, 0, -1);
        send_frame(8'hFF, 2'b00, 2'b11, 0, 1, 0, -1);
        drain();
        send_frame(8'h5A, 2'b00, 2'b11, 0, 1, 0, 4);
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("abort_data_out", data_out, 8'h00);
        check("abort_parity_error", 8'(parity_error), 8'd0);
        check("abort_stop_error", 8'(stop_error), 8'd0);
        check("abort_active_flag", 8'(active_flag), 8'd0);

        for (int k = 0; k < 8; k++) begin
            logic [7:0] d;
            logic [1:0] pt, br;
            bit flip, stp;
            d    = 8'($urandom);
            pt   = 2'($urandom);
            br   = 2'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            stp  = ($urandom_range(0, 4) != 0);
            send_frame(d, pt, br, flip, stp, $urandom_range(0, 2), -1);
            repeat ($urandom_range(0, 40)) @(negedge clock);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
